// File: rtl/maze_pkg.sv
// Shared grid geometry, sentinel cell values and cursor FSM encoding for the maze cursor.
package maze_pkg;

   localparam int unsigned MAZE_COLS  = 18;
   localparam int unsigned MAZE_ROWS  = 11;
   localparam int unsigned MAZE_CELLS = 198;
   localparam logic [7:0]  CELL_HIT   = 8'd255;
   localparam logic [7:0]  START_CELL = 8'd181;

   localparam logic [1:0] PLAY = 2'd0;
   localparam logic [1:0] HIT  = 2'd1;
   localparam logic [1:0] OVER = 2'd2;

   typedef enum logic [1:0] {
      StPlay = PLAY,
      StHit  = HIT,
      StOver = OVER
   } cursor_state_e;

endpackage

// File: rtl/step_tick_gen.sv
// Step prescaler: pulses tick for one CLK on the last cycle of every DIV-cycle period.
module step_tick_gen #(
   parameter int unsigned DIV = 625000
) (
   input  logic CLK,
   input  logic RESET,
   output logic tick
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntW'(DIV - 1));

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/maze_cursor_ctrl.sv
// Player cursor controller: steps the cursor cell on each step tick, handles wall hits and respawn.
// Optional life counting and game-over state are enabled by defining CURSOR_LIVES_EN.
module maze_cursor_ctrl
   import maze_pkg::*;
#(
   parameter int unsigned COLS       = MAZE_COLS,
   parameter int unsigned ROWS       = MAZE_ROWS,
   parameter int unsigned STEP_DIV   = 625000,
   parameter int unsigned HIT_TICKS  = 10,
   parameter logic [7:0]  START_CELL = 8'd181
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic [COLS*ROWS-1:0] mazestate,
   input  logic [7:0]           begin_spot,
   output logic [7:0]           count,
   output logic                 hit,
   output logic                 step_tick,
   output logic [1:0]           lives,
   output logic                 game_over
);

   localparam int unsigned Cells = COLS * ROWS;
   localparam int unsigned HoldW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

   cursor_state_e    state_q, state_d;
   logic [7:0]       count_q, count_d;
   logic [HoldW-1:0] hold_q, hold_d;

   logic       tick;
   logic [7:0] row, col, target, respawn;
   logic       move_req, off_grid, target_open;

   step_tick_gen #(
      .DIV (STEP_DIV)
   ) u_step_tick_gen (
      .CLK   (CLK),
      .RESET (RESET),
      .tick  (tick)
   );

   assign row     = count_q / 8'(COLS);
   assign col     = count_q % 8'(COLS);
   assign respawn = (begin_spot > 8'(Cells - 1)) ? START_CELL : begin_spot;

   // Only the highest-priority pressed button produces a move request.
   always_comb begin
      move_req = 1'b1;
      off_grid = 1'b0;
      target   = count_q;
      if (btn_up) begin
         off_grid = (row == 8'd0);
         target   = count_q - 8'(COLS);
      end else if (btn_down) begin
         off_grid = (row == 8'(ROWS - 1));
         target   = count_q + 8'(COLS);
      end else if (btn_left) begin
         off_grid = (col == 8'd0);
         target   = count_q - 8'd1;
      end else if (btn_right) begin
         off_grid = (col == 8'(COLS - 1));
         target   = count_q + 8'd1;
      end else begin
         move_req = 1'b0;
      end
      target_open = (target < 8'(Cells)) && mazestate[target];
   end

`ifdef CURSOR_LIVES_EN
   logic [1:0] lives_q, lives_d;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hold_d  = hold_q;
`ifdef CURSOR_LIVES_EN
      lives_d = lives_q;
`endif
      if (tick) begin
         unique case (state_q)
            StPlay: begin
               if (move_req && !off_grid) begin
                  if (target_open) begin
                     count_d = target;
                  end else begin
                     count_d = CELL_HIT;
                     hold_d  = '0;
`ifdef CURSOR_LIVES_EN
                     if (lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = StOver;
                     end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = StHit;
                     end
`else
                     state_d = StHit;
`endif
                  end
               end
            end
            StHit: begin
               if (hold_q == HoldW'(HIT_TICKS - 1)) begin
                  count_d = respawn;
                  state_d = StPlay;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            StOver: state_d = StOver;
            default: state_d = StPlay;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= StPlay;
         count_q <= START_CELL;
         hold_q  <= '0;
`ifdef CURSOR_LIVES_EN
         lives_q <= 2'd3;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hold_q  <= hold_d;
`ifdef CURSOR_LIVES_EN
         lives_q <= lives_d;
`endif
      end
   end

   assign count     = count_q;
   assign hit       = (state_q != StPlay);
   assign step_tick = tick;
`ifdef CURSOR_LIVES_EN
   assign lives     = lives_q;
   assign game_over = (state_q == StOver);
`else
   assign lives     = 2'd3;
   assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_maze_cursor_ctrl.sv
// Bench for maze_cursor_ctrl: directed scenarios plus randomized play against a row/col grid model.
module tb_maze_cursor_ctrl;

   localparam int unsigned STEP_DIV  = 4;
   localparam int unsigned HIT_TICKS = 3;

   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic [197:0] mazestate = '1;
   logic [7:0]   begin_spot = 8'd0;
   logic [7:0]   count;
   logic         hit, step_tick, game_over;
   logic [1:0]   lives;

   int checks = 0;
   int errors = 0;

   // Reference model: cursor position as row/col, plus mode flags and tick phase.
   int m_row, m_col, m_hold, m_pre, m_lives;
   bit m_inhit, m_over;

   maze_cursor_ctrl #(
      .STEP_DIV  (STEP_DIV),
      .HIT_TICKS (HIT_TICKS)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .mazestate  (mazestate),
      .begin_spot (begin_spot),
      .count      (count),
      .hit        (hit),
      .step_tick  (step_tick),
      .lives      (lives),
      .game_over  (game_over)
   );

   always #5 CLK = ~CLK;

   function automatic int m_count();
      return (m_inhit || m_over) ? 255 : m_row * 18 + m_col;
   endfunction

   task automatic model_reset();
      m_row = 10; m_col = 1; m_hold = 0; m_pre = 0; m_lives = 3;
      m_inhit = 0; m_over = 0;
   endtask

   task automatic model_edge();
      bit tick;
      int dr, dc, nr, nc, spot;
      tick = (m_pre == STEP_DIV - 1);
      if (!RESET) begin
         model_reset();
         return;
      end
      m_pre = tick ? 0 : m_pre + 1;
      if (!tick || m_over) return;
      if (m_inhit) begin
         if (m_hold == HIT_TICKS - 1) begin
            m_inhit = 0;
            spot = (begin_spot > 197) ? 181 : int'(begin_spot);
            m_row = spot / 18;
            m_col = spot % 18;
         end else begin
            m_hold++;
         end
         return;
      end
      dr = 0; dc = 0;
      if (btn_up) dr = -1;
      else if (btn_down) dr = 1;
      else if (btn_left) dc = -1;
      else if (btn_right) dc = 1;
      if (dr == 0 && dc == 0) return;
      nr = m_row + dr;
      nc = m_col + dc;
      if (nr < 0 || nr > 10 || nc < 0 || nc > 17) return;
      if (mazestate[nr * 18 + nc]) begin
         m_row = nr;
         m_col = nc;
      end else begin
`ifdef CURSOR_LIVES_EN
         if (m_lives == 1) begin
            m_lives = 0;
            m_over = 1;
         end else begin
            m_lives--;
            m_inhit = 1;
            m_hold = 0;
         end
`else
         m_inhit = 1;
         m_hold = 0;
`endif
      end
   endtask

   // Inputs change only after a negedge; the model sees the same values the DUT samples.
   task automatic clk_cycle();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
      mazestate = '1;
      RESET = 0;
      clk_cycle();
      RESET = 1;
   endtask

   task automatic run_tick();
      for (int i = 0; i < int'(STEP_DIV) && m_pre != STEP_DIV - 1; i++) clk_cycle();
      checks++;
      if (step_tick !== 1'b1) begin
         errors++;
         $display("FAIL step_tick_pulse: got %b want 1", step_tick);
      end
      clk_cycle();
   endtask

   // Move the cursor anywhere by walking into a wall and respawning at spot.
   task automatic teleport(input int spot, input int expect_cell);
      mazestate = '1;
      if (m_row > 0) begin
         mazestate[(m_row - 1) * 18 + m_col] = 1'b0;
         btn_up = 1;
      end else begin
         mazestate[(m_row + 1) * 18 + m_col] = 1'b0;
         btn_down = 1;
      end
      begin_spot = 8'(spot);
      for (int i = 0; i < 4 * int'(STEP_DIV) && !m_inhit; i++) clk_cycle();
      btn_up = 0; btn_down = 0;
      mazestate = '1;
      for (int i = 0; i < (HIT_TICKS + 2) * STEP_DIV && m_inhit; i++) clk_cycle();
      checks++;
      if (count !== 8'(expect_cell)) begin
         errors++;
         $display("FAIL teleport: count=%0d want %0d", count, expect_cell);
      end
   endtask

   task automatic test_reset();
      model_reset();
      RESET = 0;
      clk_cycle();
      clk_cycle();
      checks += 4;
      if (count !== 8'd181) begin errors++; $display("FAIL reset_count: %0d want 181", count); end
      if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: %b want 0", hit); end
      if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives: %0d want 3", lives); end
      if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: %b want 0", game_over); end
      RESET = 1;
      checks++;
      if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: %b want 0", step_tick); end
      run_tick();
      checks++;
      if (count !== 8'd181) begin errors++; $display("FAIL idle_tick: count=%0d want 181", count); end
   endtask

   task automatic test_up_hold();
      do_reset();
      btn_up = 1;
      for (int i = 0; i < int'(STEP_DIV) && m_pre != STEP_DIV - 1; i++) clk_cycle();
      checks += 2;
      if (step_tick !== 1'b1) begin errors++; $display("FAIL up_tick: %b want 1", step_tick); end
      if (count !== 8'd181) begin errors++; $display("FAIL up_pre: count=%0d want 181", count); end
      clk_cycle();
      checks++;
      if (count !== 8'd163) begin errors++; $display("FAIL up_first: count=%0d want 163", count); end
      run_tick();
      checks++;
      if (count !== 8'd145) begin errors++; $display("FAIL up_second: count=%0d want 145", count); end
      btn_up = 0;
   endtask

   task automatic test_boundaries();
      do_reset();
      teleport(162, 162);
      btn_left = 1;
      run_tick();
      btn_left = 0;
      checks++;
      if (count !== 8'd162) begin errors++; $display("FAIL left_edge: count=%0d want 162", count); end
      do_reset();
      teleport(17, 17);
      btn_up = 1;
      run_tick();
      btn_up = 0;
      checks++;
      if (count !== 8'd17) begin errors++; $display("FAIL top_edge: count=%0d want 17", count); end
      btn_right = 1;
      run_tick();
      btn_right = 0;
      checks++;
      if (count !== 8'd17) begin errors++; $display("FAIL right_edge: count=%0d want 17", count); end
      do_reset();
      btn_down = 1;
      run_tick();
      btn_down = 0;
      checks++;
      if (count !== 8'd181) begin errors++; $display("FAIL bottom_edge: count=%0d want 181", count); end
   endtask

   task automatic test_priority();
      do_reset();
      btn_up = 1; btn_right = 1;
      run_tick();
      btn_up = 0; btn_right = 0;
      checks++;
      if (count !== 8'd163) begin errors++; $display("FAIL priority: count=%0d want 163", count); end
   endtask

   task automatic test_wall_hit();
      int hit_ticks;
      do_reset();
      mazestate[163] = 1'b0;
      begin_spot = 8'd31;
      btn_up = 1;
      run_tick();
      btn_up = 0;
      checks += 2;
      if (count !== 8'd255) begin errors++; $display("FAIL wall_count: %0d want 255", count); end
      if (hit !== 1'b1) begin errors++; $display("FAIL wall_hit: %b want 1", hit); end
      hit_ticks = 0;
      for (int t = 0; t < 6 && hit === 1'b1; t++) begin
         hit_ticks++;
         run_tick();
      end
      checks += 3;
      if (hit_ticks != int'(HIT_TICKS)) begin
         errors++;
         $display("FAIL wall_hold: %0d ticks want %0d", hit_ticks, HIT_TICKS);
      end
      if (count !== 8'd31) begin errors++; $display("FAIL respawn_count: %0d want 31", count); end
      if (hit !== 1'b0) begin errors++; $display("FAIL respawn_hit: %b want 0", hit); end
      do_reset();
      teleport(220, 181);
   endtask

   task automatic test_reset_mid_hit();
      do_reset();
      mazestate[163] = 1'b0;
      begin_spot = 8'd31;
      btn_up = 1;
      run_tick();
      btn_up = 0;
      clk_cycle();
      RESET = 0;
      clk_cycle();
      RESET = 1;
      checks += 2;
      if (count !== 8'd181) begin errors++; $display("FAIL midhit_count: %0d want 181", count); end
      if (hit !== 1'b0) begin errors++; $display("FAIL midhit_hit: %b want 0", hit); end
   endtask

`ifdef CURSOR_LIVES_EN
   task automatic test_lives();
      logic [1:0] exp_lives [3];
      exp_lives = '{2'd2, 2'd1, 2'd0};
      do_reset();
      begin_spot = 8'd181;
      for (int k = 0; k < 3; k++) begin
         mazestate = '1;
         mazestate[163] = 1'b0;
         btn_up = 1;
         run_tick();
         btn_up = 0;
         checks++;
         if (lives !== exp_lives[k]) begin
            errors++;
            $display("FAIL lives_%0d: %0d want %0d", k, lives, exp_lives[k]);
         end
         if (k < 2) for (int t = 0; t < int'(HIT_TICKS); t++) run_tick();
      end
      btn_up = 1; btn_left = 1;
      for (int t = 0; t < 3; t++) run_tick();
      btn_up = 0; btn_left = 0;
      checks += 3;
      if (count !== 8'd255) begin errors++; $display("FAIL over_count: %0d want 255", count); end
      if (game_over !== 1'b1) begin errors++; $display("FAIL over_flag: %b want 1", game_over); end
      if (hit !== 1'b1) begin errors++; $display("FAIL over_hit: %b want 1", hit); end
      do_reset();
      checks += 2;
      if (lives !== 2'd3) begin errors++; $display("FAIL over_reset_lives: %0d want 3", lives); end
      if (game_over !== 1'b0) begin errors++; $display("FAIL over_reset_flag: %b", game_over); end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 198; i++) mazestate[i] = ($urandom_range(0, 3) != 0);
      begin_spot = 8'($urandom_range(0, 210));
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($urandom_range(0, 5) == 0) begin
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_down  = ($urandom_range(0, 3) == 0);
            btn_left  = ($urandom_range(0, 3) == 0);
            btn_right = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 40) == 0) begin_spot = 8'($urandom_range(0, 210));
         if ($urandom_range(0, 200) == 0) mazestate[$urandom_range(0, 197)] ^= 1'b1;
         RESET = ($urandom_range(0, 400) != 0);
         clk_cycle();
         checks += 5;
         if (count !== 8'(m_count())) begin
            errors++;
            $display("FAIL rand_count@%0d: %0d want %0d", cyc, count, m_count());
         end
         if (hit !== (m_inhit || m_over)) begin
            errors++;
            $display("FAIL rand_hit@%0d: %b want %b", cyc, hit, m_inhit || m_over);
         end
         if (step_tick !== (m_pre == STEP_DIV - 1)) begin
            errors++;
            $display("FAIL rand_tick@%0d: %b want %b", cyc, step_tick, m_pre == STEP_DIV - 1);
         end
         if (lives !== 2'(m_lives)) begin
            errors++;
            $display("FAIL rand_lives@%0d: %0d want %0d", cyc, lives, m_lives);
         end
         if (game_over !== m_over) begin
            errors++;
            $display("FAIL rand_over@%0d: %b want %b", cyc, game_over, m_over);
         end
      end
      RESET = 1;
   endtask

   initial begin
      test_reset();
      test_up_hold();
      test_boundaries();
      test_priority();
      test_wall_hit();
      test_reset_mid_hit();
`ifdef CURSOR_LIVES_EN
      test_lives();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
